// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg
// Shared definitions for the SPI register file: the frame layout constants
// and the frame-level FSM state encoding.
//   CMD_W  : command byte width (R/W bit followed by the address)
//   RW_BIT : bit index of the R/W flag inside the command byte (1 = write)
//   ADDR_W : register address width
package spi_regfile_pkg;

    localparam int CMD_W  = 8;
    localparam int RW_BIT = 7;
    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,   // waiting for ncs to fall
        CMD  = 3'd1,   // shifting in R/W + address
        DATA = 3'd2,   // shifting data in (write) or out (read)
        DONE = 3'd3,   // full frame received, waiting for ncs to rise
        DROP = 3'd4    // too many clocks seen, frame will be rejected
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Two-flop synchroniser for one asynchronous input, plus single-clk rise and
// fall pulses derived from the synchronised level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level (resets to RESET_VAL)
//   rise, fall : one-clk pulses on synchronised edges
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync_1;
    logic       sync_2;
    logic       prev;
    // Edges are suppressed until the chain has refilled from the pin after
    // reset, so a pin that differs from RESET_VAL does not fake an edge.
    logic [2:0] arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
            prev   <= RESET_VAL;
            arm    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            prev   <= sync_2;
            arm    <= {arm[1:0], 1'b1};
        end
    end

    assign level = sync_2;
    assign rise  = arm[2] &  sync_2 & ~prev;
    assign fall  = arm[2] & ~sync_2 &  prev;

endmodule

// File: rtl/spi_regfile.sv
// spi_regfile
// SPI (mode 0) peripheral giving read/write access to NUM_REGS registers of
// DATA_W bits. Frame: R/W bit (1 = write), 7 address bits, DATA_W data bits,
// MSB first. A write commits only when ncs rises after exactly the right
// number of bits; short, long and out-of-range frames pulse err instead.
//   clk, rst_n       : system clock (>= 8x sclk), async active-low reset
//   sclk, copi, ncs  : SPI pins, asynchronous to clk
//   cipo, cipo_oe    : read data out and its output enable
//   regs_flat        : register r at [r*DATA_W +: DATA_W]
//   wr_strobe        : one-clk pulse per committed write
//   wr_addr          : address of the last committed write
//   err              : one-clk pulse per rejected frame
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       err
);

    localparam int         CNT_W      = 5;
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    state_t state, state_nx;

    logic sclk_rise, sclk_fall, copi_s, ncs_rise, ncs_fall;
    logic unused_sclk_lvl, unused_copi_rise, unused_copi_fall, unused_ncs_lvl;

    logic [DATA_W-1:0] sr, shift_in, rd_sr, rd_val;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q, cmd_addr;
    logic              addr_ok;
    logic clr_frame, sample, cmd_done, commit, reject, rd_shift;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_s), .rise(unused_copi_rise), .fall(unused_copi_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(unused_ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign shift_in = {sr[DATA_W-2:0], copi_s};
    assign cmd_addr = shift_in[ADDR_W-1:0];
    assign addr_ok  = {1'b0, addr_q} < NUM_REGS_W;

    // Read data for the address completing in this very sample.
    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cmd_addr == ADDR_W'(r)) rd_val = regs_flat[r*DATA_W +: DATA_W];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM: next state. An ncs fall restarts the frame from any state.
    always_comb begin
        state_nx = state;
        if (ncs_fall) begin
            state_nx = CMD;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                CMD: begin
                    if (ncs_rise) state_nx = IDLE;
                    else if (sclk_rise && bit_cnt == CNT_W'(CMD_W - 1)) state_nx = DATA;
                end
                DATA: begin
                    if (ncs_rise) state_nx = IDLE;
                    else if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1)) state_nx = DONE;
                end
                DONE: begin
                    if (ncs_rise)       state_nx = IDLE;
                    else if (sclk_rise) state_nx = DROP;
                end
                DROP: if (ncs_rise) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM: outputs and datapath controls. commit and reject are exclusive.
    always_comb begin
        clr_frame = 1'b0;
        sample    = 1'b0;
        cmd_done  = 1'b0;
        commit    = 1'b0;
        reject    = 1'b0;
        rd_shift  = 1'b0;
        cipo_oe   = (state == DATA) && !rw_q;
        cipo      = cipo_oe & rd_sr[DATA_W-1];
        if (ncs_fall) begin
            clr_frame = 1'b1;
        end else begin
            case (state)
                CMD: begin
                    if (ncs_rise) reject = 1'b1;
                    else if (sclk_rise) begin
                        sample   = 1'b1;
                        cmd_done = (bit_cnt == CNT_W'(CMD_W - 1));
                    end
                end
                DATA: begin
                    if (ncs_rise) reject = 1'b1;
                    else begin
                        sample = sclk_rise;
                        // The MSB is already on cipo when DATA is entered;
                        // advance only after a data-phase bit was sampled.
                        rd_shift = sclk_fall && !rw_q && (bit_cnt != '0);
                    end
                end
                DONE: begin
                    if (ncs_rise) begin
                        if (!addr_ok)  reject = 1'b1;
                        else if (rw_q) commit = 1'b1;
                    end
                end
                DROP: if (ncs_rise) reject = 1'b1;
                default: ;
            endcase
        end
    end

    // Frame datapath: shift register, bit counter, command latch, read shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            rd_sr   <= '0;
        end else if (clr_frame) begin
            sr      <= '0;
            bit_cnt <= '0;
            rd_sr   <= '0;
        end else begin
            if (sample) begin
                if (cmd_done) begin
                    sr      <= '0;
                    bit_cnt <= '0;
                    rw_q    <= shift_in[RW_BIT];
                    addr_q  <= cmd_addr;
                    rd_sr   <= shift_in[RW_BIT] ? '0 : rd_val;
                end else begin
                    sr      <= shift_in;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (rd_shift) rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
        end
    end

    // Register file and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_flat <= {NUM_REGS{RESET_VAL}};
            wr_strobe <= 1'b0;
            err       <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit;
            err       <= reject;
            if (commit) begin
                wr_addr <= addr_q;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (addr_q == ADDR_W'(r)) regs_flat[r*DATA_W +: DATA_W] <= sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile
// Directed bench for spi_regfile: an 8-bit, 5-register instance and a
// 16-bit, 20-register instance with a non-zero reset value.
module tb_spi_regfile;

    localparam int HALF = 100;  // half sclk period in ns (clk period 10 ns)

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0: DATA_W=8, NUM_REGS=5 ----------------
    logic        sclk0 = 1'b0, copi0 = 1'b0, ncs0 = 1'b1;
    logic        cipo0, oe0, ws0, err0;
    logic [39:0] regs0;
    logic [6:0]  wa0;

    spi_regfile #(.NUM_REGS(5), .DATA_W(8), .RESET_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .copi(copi0), .ncs(ncs0),
        .cipo(cipo0), .cipo_oe(oe0), .regs_flat(regs0),
        .wr_strobe(ws0), .wr_addr(wa0), .err(err0)
    );

    // ---------------- DUT 1: DATA_W=16, NUM_REGS=20 ----------------
    logic         sclk1 = 1'b0, copi1 = 1'b0, ncs1 = 1'b1;
    logic         cipo1, oe1, ws1, err1;
    logic [319:0] regs1;
    logic [6:0]   wa1;

    spi_regfile #(.NUM_REGS(20), .DATA_W(16), .RESET_VAL(16'h1234)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .copi(copi1), .ncs(ncs1),
        .cipo(cipo1), .cipo_oe(oe1), .regs_flat(regs1),
        .wr_strobe(ws1), .wr_addr(wa1), .err(err1)
    );

    // ---------------- pulse monitor ----------------
    int         ws_cnt0, err_cnt0, ws_cnt1, err_cnt1, both_cnt;
    logic [6:0] last_wa0 = '0, last_wa1 = '0;

    always @(negedge clk) begin
        if (ws0)  begin ws_cnt0++; last_wa0 = wa0; end
        if (err0) err_cnt0++;
        if (ws1)  begin ws_cnt1++; last_wa1 = wa1; end
        if (err1) err_cnt1++;
        if ((ws0 && err0) || (ws1 && err1)) both_cnt++;
    end

    // ---------------- scoreboard ----------------
    int            chk_cnt, pass_cnt;
    logic [15:0]   exp_q[$];
    logic [39:0]   exp0;
    logic [319:0]  exp1;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic set_pins(input bit which, input logic s, input logic c);
        if (which) begin sclk1 = s; copi1 = c; end
        else       begin sclk0 = s; copi0 = c; end
    endtask

    task automatic set_ncs(input bit which, input logic n);
        if (which) ncs1 = n;
        else       ncs0 = n;
    endtask

    // One mode-0 bit: present copi, sample cipo just before the rising edge.
    task automatic send_bit(input bit which, input logic b, output logic so, output logic oe);
        set_pins(which, 1'b0, b);
        #HALF;
        so = which ? cipo1 : cipo0;
        oe = which ? oe1 : oe0;
        set_pins(which, 1'b1, b);
        #HALF;
        set_pins(which, 1'b0, b);
    endtask

    // Full frame of nbits (MSB = bits[nbits-1]). Returns read bits after the
    // command byte, count of samples with cipo_oe high, and the number of clk
    // edges from the ncs rise to a visible wr_strobe (-1 if none).
    task automatic frame(input bit which, input logic [31:0] bits, input int nbits,
                         output logic [15:0] rx, output int oe_n, output int lat);
        logic so, oe;
        rx = '0; oe_n = 0; lat = -1;
        set_ncs(which, 1'b0);
        #HALF;
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(which, bits[i], so, oe);
            if (i < nbits - 8) rx = {rx[14:0], so};
            if (oe) oe_n++;
        end
        #HALF;
        @(posedge clk); #1;
        set_ncs(which, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (lat < 0 && (which ? ws1 : ws0)) lat = k;
        end
        repeat (10) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] rx;
    int oe_n, lat, ws_b, er_b;
    logic so_d, oe_d;

    initial begin
        exp0 = '0;
        exp1 = {20{16'h1234}};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_regs0", regs0, exp0);
        chk("rst_regs1", regs1, exp1);
        chk("rst_outs0", {cipo0, oe0, ws0, err0, wa0}, '0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // write 0xA5 to addr 0
        ws_b = ws_cnt0; er_b = err_cnt0;
        frame(1'b0, {8'h80, 8'hA5}, 16, rx, oe_n, lat);
        exp0[7:0] = 8'hA5;
        chk("wr0_regs", regs0, exp0);
        chk("wr0_strobe_cnt", ws_cnt0 - ws_b, 1);
        chk("wr0_addr", last_wa0, 7'd0);
        chk("wr0_err_cnt", err_cnt0 - er_b, 0);
        chk("wr0_latency_ok", (lat >= 1 && lat <= 4), 1);
        chk("wr0_no_oe", oe_n, 0);

        // write 0x3C to addr 2, then read it back (copi data ignored)
        frame(1'b0, {8'h82, 8'h3C}, 16, rx, oe_n, lat);
        exp0[23:16] = 8'h3C;
        chk("wr2_regs", regs0, exp0);
        chk("wr2_addr", last_wa0, 7'd2);
        ws_b = ws_cnt0; er_b = err_cnt0;
        exp_q.push_back(16'h003C);
        frame(1'b0, {8'h02, 8'h55}, 16, rx, oe_n, lat);
        chk("rd2_data", rx, exp_q.pop_front());
        chk("rd2_oe_cnt", oe_n, 8);
        chk("rd2_regs", regs0, exp0);
        chk("rd2_strobe_cnt", ws_cnt0 - ws_b, 0);
        chk("rd2_err_cnt", err_cnt0 - er_b, 0);
        chk("rd2_idle_outs", {cipo0, oe0}, 2'b00);

        // write to addr 5 (out of range)
        ws_b = ws_cnt0; er_b = err_cnt0;
        frame(1'b0, {8'h85, 8'hFF}, 16, rx, oe_n, lat);
        chk("wr5_err_cnt", err_cnt0 - er_b, 1);
        chk("wr5_strobe_cnt", ws_cnt0 - ws_b, 0);
        chk("wr5_regs", regs0, exp0);

        // read of addr 0x7F (out of range)
        er_b = err_cnt0;
        exp_q.push_back(16'h0000);
        frame(1'b0, {8'h7F, 8'h00}, 16, rx, oe_n, lat);
        chk("rd7f_data", rx, exp_q.pop_front());
        chk("rd7f_oe_cnt", oe_n, 8);
        chk("rd7f_err_cnt", err_cnt0 - er_b, 1);

        // short frame: 12 bits
        ws_b = ws_cnt0; er_b = err_cnt0;
        frame(1'b0, {8'h81, 4'hF}, 12, rx, oe_n, lat);
        chk("short_err_cnt", err_cnt0 - er_b, 1);
        chk("short_strobe_cnt", ws_cnt0 - ws_b, 0);
        chk("short_regs", regs0, exp0);

        // long frame: 17 bits
        ws_b = ws_cnt0; er_b = err_cnt0;
        frame(1'b0, {8'h81, 8'hFF, 1'b1}, 17, rx, oe_n, lat);
        chk("long_err_cnt", err_cnt0 - er_b, 1);
        chk("long_strobe_cnt", ws_cnt0 - ws_b, 0);
        chk("long_regs", regs0, exp0);

        // top in-range address: write 0x77 to addr 4 and read it back
        frame(1'b0, {8'h84, 8'h77}, 16, rx, oe_n, lat);
        exp0[39:32] = 8'h77;
        chk("wr4_regs", regs0, exp0);
        chk("wr4_addr", last_wa0, 7'd4);
        exp_q.push_back(16'h0077);
        frame(1'b0, {8'h04, 8'h00}, 16, rx, oe_n, lat);
        chk("rd4_data", rx, exp_q.pop_front());

        // reset pulsed in the middle of a write data phase
        ws_b = ws_cnt0; er_b = err_cnt0;
        set_ncs(1'b0, 1'b0);
        #HALF;
        for (int i = 7; i >= 0; i--) send_bit(1'b0, 8'h81 >> i, so_d, oe_d);
        for (int i = 0; i < 4; i++)  send_bit(1'b0, 1'b1, so_d, oe_d);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp0 = '0;
        chk("midrst_regs_in_reset", regs0, exp0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)  send_bit(1'b0, 1'b1, so_d, oe_d);
        #HALF;
        set_ncs(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("midrst_regs_after", regs0, exp0);
        chk("midrst_strobe_cnt", ws_cnt0 - ws_b, 0);
        chk("midrst_err_cnt", err_cnt0 - er_b, 0);
        ws_b = ws_cnt0;
        frame(1'b0, {8'h83, 8'h99}, 16, rx, oe_n, lat);
        exp0[31:24] = 8'h99;
        chk("postrst_regs", regs0, exp0);
        chk("postrst_strobe_cnt", ws_cnt0 - ws_b, 1);
        chk("postrst_addr", last_wa0, 7'd3);
        chk("postrst_regs1", regs1, exp1);

        // 16-bit instance: write 0xBEEF to addr 19
        ws_b = ws_cnt1; er_b = err_cnt1;
        frame(1'b1, {8'h93, 16'hBEEF}, 24, rx, oe_n, lat);
        exp1[19*16 +: 16] = 16'hBEEF;
        chk("w16_regs", regs1, exp1);
        chk("w16_strobe_cnt", ws_cnt1 - ws_b, 1);
        chk("w16_addr", last_wa1, 7'h13);
        chk("w16_err_cnt", err_cnt1 - er_b, 0);

        chk("strobe_err_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of DATA_W-bit registers (addresses 0..NUM_REGS-1, max 128).
REQ-002 SHALL have parameter DATA_W, default 8, register and data-phase width (8 or 16).
REQ-003 SHALL have parameter RESET_VAL, default 0, reset value of every register.
REQ-004 SHALL have port clk input 1: system clock; at least 8x SCLK frequency.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port sclk input 1: SPI clock, mode 0, asynchronous to clk.
REQ-007 SHALL have port copi input 1: controller-out data, asynchronous.
REQ-008 SHALL have port ncs input 1: chip select, active-low, asynchronous.
REQ-009 SHALL have port cipo output 1: peripheral-out read data.
REQ-010 SHALL have port cipo_oe output 1: high while a read data phase is active.
REQ-011 SHALL have port regs_flat output NUM_REGS*DATA_W: register r at bits [r*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_strobe output 1: one-clk pulse on each committed write.
REQ-013 SHALL have port wr_addr output 7: address of the last committed write.
REQ-014 SHALL have port err output 1: one-clk pulse on each rejected frame.

Function
REQ-015 SHALL synchronise sclk, copi and ncs through two flops each, with edge detection on the synchronised sclk and ncs.
REQ-016 SHALL frame each transaction as 1 R/W bit (1 = write), then 7 address bits, then DATA_W data bits, all MSB first and sampled on the synchronised sclk rising edge.
REQ-017 SHALL use FSM states IDLE, CMD, DATA, DONE, DROP.
REQ-018 SHALL move IDLE->CMD on the ncs falling edge, clearing the shift register and the bit counter.
REQ-019 SHALL move CMD->DATA after 8 sampled bits, latching R/W and the address.
REQ-020 SHALL move DATA->DONE after DATA_W further bits.
REQ-021 SHALL move CMD or DATA->IDLE on an ncs rising edge and discard the frame with an err pulse (short frame).
REQ-022 SHALL move DONE->DROP on any extra sclk rising edge, and DROP->IDLE on ncs rise with an err pulse and no commit (long frame).
REQ-023 SHALL, on an ncs rising edge in DONE for a write with address < NUM_REGS, update the register on the next clk edge and pulse wr_strobe with wr_addr = address, the whole sequence within 4 clk of the ncs pin edge.
REQ-024 SHALL pulse err for a write with address >= NUM_REGS, leaving all registers unchanged.
REQ-025 SHALL, for a read, load a read shift register with reg[addr] (0 if addr >= NUM_REGS, plus an err pulse at ncs rise) at the CMD->DATA transition.
REQ-026 SHALL assert cipo_oe during a read data phase and drive the data MSB first, updating cipo on each synchronised sclk falling edge, with the first bit valid before the first data-phase rising edge.
REQ-027 SHALL hold cipo=0 and cipo_oe=0 outside a read data phase.
REQ-028 SHALL ignore copi data bits during a read; registers are unchanged.
REQ-029 SHALL keep wr_strobe and err mutually exclusive, each at most one pulse per frame.
REQ-030 SHALL restart a frame cleanly on an ncs falling edge arriving in any state.

Reset
REQ-031 SHALL, on rst_n low, set all registers to RESET_VAL, the FSM to IDLE, counters and shift registers to 0, cipo, cipo_oe, wr_strobe and err to 0, wr_addr to 0, and the synchroniser flops with ncs to 1 and sclk and copi to 0.
REQ-032 SHALL abandon a frame in progress when reset asserts, with no commit; after release the block waits for a fresh ncs falling edge.

Structure
REQ-033 SHALL place the FSM state enum, CMD_W=8, the RW_BIT index and ADDR_W=7 in package spi_regfile_pkg.
REQ-034 SHALL implement sub-module spi_sync_edge (2-flop synchroniser with rise/fall pulses, rst_n reset to a parameter value) and instantiate it for sclk, copi (level only) and ncs.

Verification
REQ-035 SHALL cover: write 0x80,0xA5 (addr 0) -> regs_flat[7:0]=0xA5, one wr_strobe, wr_addr=0, no err.
REQ-036 SHALL cover: after writing 0x3C to addr 2, read 0x02 -> cipo shifts 0x3C MSB first, cipo_oe high for 8 sclk, registers unchanged.
REQ-037 SHALL cover: write 0x85,0xFF with NUM_REGS=5 -> err pulse, all registers unchanged; read of addr 0x7F -> cipo shifts 0x00 and err pulses.
REQ-038 SHALL cover: ncs raised after 12 bits -> err, no write; 17 bits clocked -> err, no write.
REQ-039 SHALL cover: rst_n pulsed low mid data phase -> all registers at RESET_VAL; the next full frame commits correctly.
REQ-040 SHALL cover: DATA_W=16, NUM_REGS=20, write 0x93,0xBEEF -> register 19 = 0xBEEF.
